// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: watches a multiplexed active-low 7-segment bus, waits for
// each digit to settle, decodes it back to a nibble and assembles full frames.
module seg_scan_decoder #(
   parameter int NUM_DIGITS    = 8,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [6:0]              seg_in,
   input  logic [NUM_DIGITS-1:0]   dig_sel_n,
   output logic [4*NUM_DIGITS-1:0] word_out,
   output logic                    word_valid,
   output logic                    word_err,
   output logic                    pattern_err
);

   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLING, ST_CAPTURED} state_t;

   state_t                  r_state, w_state_nx;
   logic [7:0]              r_cnt, w_cnt_nx;
   logic [6:0]              r_seg, r_seg_p;
   logic [NUM_DIGITS-1:0]   r_dig, r_dig_p;
   logic [4*NUM_DIGITS-1:0] r_slots;
   logic [NUM_DIGITS-1:0]   r_slot_err, r_mask;

   logic [3:0]              w_nib;
   logic                    w_bad;
   int                      w_low_cnt;
   logic [IW-1:0]           w_idx;
   logic                    w_legal, w_changed, w_capture, w_full;
   logic [NUM_DIGITS-1:0]   w_onehot, w_mask_nx, w_err_nx;

   // Decode the registered segment pattern back to a hex nibble.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can leave it unassigned and infer a latch.
      w_nib = 4'h0;
      w_bad = 1'b0;
      case (r_seg)
         7'h40: w_nib = 4'h0;
         7'h79: w_nib = 4'h1;
         7'h24: w_nib = 4'h2;
         7'h30: w_nib = 4'h3;
         7'h19: w_nib = 4'h4;
         7'h12: w_nib = 4'h5;
         7'h02: w_nib = 4'h6;
         7'h78: w_nib = 4'h7;
         7'h00: w_nib = 4'h8;
         7'h10: w_nib = 4'h9;
         7'h08: w_nib = 4'hA;
         7'h03: w_nib = 4'hB;
         7'h46: w_nib = 4'hC;
         7'h21: w_nib = 4'hD;
         7'h06: w_nib = 4'hE;
         7'h0E: w_nib = 4'hF;
         default: w_bad = 1'b1;
      endcase
   end

   // Classify the registered digit select: legal only with exactly one line low.
   always_comb begin
      w_low_cnt = 0;
      w_idx     = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!r_dig[i]) begin
            w_low_cnt = w_low_cnt + 1;
            w_idx     = IW'(i);
         end
      end
      w_legal   = (w_low_cnt == 1);
      w_onehot  = ~r_dig;
      w_changed = (r_seg != r_seg_p) || (r_dig != r_dig_p);
   end

   // Settle FSM next state: r_cnt counts repeats after the first legal sample.
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_capture  = 1'b0;
      if (!w_legal) begin
         w_state_nx = ST_IDLE;
         w_cnt_nx   = 8'd0;
      end else if (w_changed || (r_state == ST_IDLE)) begin
         w_cnt_nx = 8'd0;
         if (SETTLE_CYCLES == 1) begin
            w_capture  = 1'b1;
            w_state_nx = ST_CAPTURED;
         end else begin
            w_state_nx = ST_SETTLING;
         end
      end else if (r_state == ST_CAPTURED) begin
         if (r_cnt != 8'hFF) w_cnt_nx = r_cnt + 8'd1;
      end else begin
         w_cnt_nx = r_cnt + 8'd1;
         if (({1'b0, r_cnt} + 9'd2) >= 9'(SETTLE_CYCLES)) begin
            w_capture  = 1'b1;
            w_state_nx = ST_CAPTURED;
         end
      end
   end

   // Frame bookkeeping: a full mask clears first, then this cycle's capture lands.
   always_comb begin
      w_full    = &r_mask;
      w_mask_nx = w_full ? '0 : r_mask;
      w_err_nx  = w_full ? '0 : r_slot_err;
      if (w_capture) begin
         w_mask_nx = w_mask_nx | w_onehot;
         w_err_nx  = (w_err_nx & ~w_onehot) | (w_bad ? w_onehot : '0);
      end
   end

   // Input sampling and FSM state register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      if (!rst_n) begin
         r_seg   <= '1;
         r_dig   <= '1;
         r_seg_p <= '1;
         r_dig_p <= '1;
         r_state <= ST_IDLE;
         r_cnt   <= 8'd0;
      end else begin
         r_seg   <= seg_in;
         r_dig   <= dig_sel_n;
         r_seg_p <= r_seg;
         r_dig_p <= r_dig;
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
      end
   end

   // Slot capture, frame completion and sticky pattern error.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_slots     <= '0;
         r_slot_err  <= '0;
         r_mask      <= '0;
         word_out    <= '0;
         word_valid  <= 1'b0;
         word_err    <= 1'b0;
         pattern_err <= 1'b0;
      end else begin
         r_mask      <= w_mask_nx;
         r_slot_err  <= w_err_nx;
         word_valid  <= w_full;
         pattern_err <= pattern_err | (w_capture & w_bad);
         if (w_capture) r_slots[int'(w_idx)*4 +: 4] <= w_nib;
         if (w_full) begin
            word_out <= r_slots;
            word_err <= |r_slot_err;
         end
      end
   end

endmodule
